regn_preset_en: RTL and testbench
=================================

# regn_preset_en

N-bit parallel storage register with load enable, asynchronous clear and asynchronous preset. It is a generic datapath/pipeline holding register: it captures `d` on a rising clock edge when enabled and holds otherwise. Module name is `regn_preset_en`.

## Interface
Parameters:
- `n`, default 8: data width in bits, ≥1.
- `PRESET_VAL`, default all ones (`{n{1'b1}}`): value forced onto `q` by preset.

Ports:
- `clk`  input  1: single clock; all loads on the rising edge.
- `rst`  input  1: reset, asynchronous, active-high; clears `q` to 0.
- `pst`  input  1: preset, asynchronous, active-high; forces `q` to `PRESET_VAL`.
- `en`  input  1: load enable, active-high, sampled on the rising edge of `clk`.
- `d`  input  n: parallel data in.
- `q`  output  n: registered data out.

Port order for positional instantiation: `clk, rst, pst, en, d, q`.

## Operation
- Priority, highest first: `rst`, then `pst`, then `en`, then hold.
- `rst`=1: `q` = 0 immediately, with no clock needed. It stays 0 while `rst` is held.
- `rst`=0, `pst`=1: `q` = `PRESET_VAL` immediately, with no clock needed. It stays there while held.
- `rst`=0, `pst`=0, `en`=1: `q` ← `d` on each rising `clk`.
- `rst`=0, `pst`=0, `en`=0: `q` holds its value. Changes on `d` are ignored.
- `rst` and `pst` both 1: `q` = 0, because reset wins.
- No arithmetic. Width is exactly `n`; `d` is copied bit-for-bit.

## Timing
- Reset value of `q`: all zeros. Preset value: `PRESET_VAL`.
- Assert path: `rst` or `pst` rising affects `q` combinationally through the flop's async pin. There is no cycle latency.
- Deassert path: after `rst`/`pst` drops, `q` keeps the forced value until the next rising `clk` with `en`=1.
- Load latency: 1 cycle. The `d` sampled at edge k appears on `q` just after edge k.
- `en` and `d` must meet setup/hold to `clk`. Async deassertion is not synchronized inside the block; recovery/removal timing is the integrator's responsibility.
- Reset or preset asserted mid-cycle overrides any pending load. A clock edge coinciding with async assertion yields the forced value.
- `rst` low and `pst` low after power-up without a prior reset: `q` is X until the first enabled load. This is acceptable.

## Structure
- Single module, one `always` block sensitive to `posedge clk`, `posedge rst` and `posedge pst`.
- Optional sub-module `dff_rpe` (1-bit flop with rst/pst/en), generated `n` times. The behavioural single-vector form is equally acceptable.
- No package needed. `PRESET_VAL` stays a local parameter override, not a shared constant.

## Test plan
All scenarios use `n`=8, a 20-time-unit clock period, and stimulus applied mid-low phase.
- Reset: `rst`=1 with `clk` stopped -> `q`=8'h00 immediately. Holds across edges while asserted regardless of `en`/`d`.
- Preset: `rst`=0, `pst`=1 -> `q`=8'hFF immediately, without an edge. `rst`=1 and `pst`=1 together -> `q`=8'h00.
- Load: from `q`=8'hFF, release `pst`, `en`=1, `d`=3 -> `q`=8'h03 after the next rising edge, not before.
- Hold: `en`=0, `d`=10 for 2 edges -> `q` stays 8'h03. Then `en`=1 -> `q`=8'h0A after the next edge.
- Async override mid-operation: while loading every cycle, pulse `rst` between edges -> `q`=0 at once. The next enabled edge reloads `d`.
- Parameter: `n`=1 and `n`=32 with `PRESET_VAL`=32'hA5A5_A5A5 -> preset drives that value and loads are full-width.

Source files
------------

// File: rtl/regn_preset_en_pkg.sv
// Shared defaults for the preset/enable holding register.
// Width default lives here; preset value stays a per-instance override.
package regn_preset_en_pkg;

  localparam int unsigned REGN_DEF_W = 8;

endpackage

// File: rtl/regn_preset_en_dff_rpe.sv
// One-bit flop with async clear, async preset and load enable.
// Clear outranks preset; both outrank the clocked load.
module dff_rpe
  import regn_preset_en_pkg::*;
#(
  parameter logic PV = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst or posedge pst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (pst) begin
      q <= PV;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regn_preset_en.sv
// N-bit holding register: load enable, async clear, async preset.
// Built as n independent bit cells so each bit takes its own preset value.
module regn_preset_en
  import regn_preset_en_pkg::*;
#(
  parameter int unsigned n = REGN_DEF_W,
  parameter logic [n-1:0] PRESET_VAL = {n{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  for (genvar i = 0; i < n; i++) begin : g_bit
    dff_rpe #(
      .PV(PRESET_VAL[i])
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .pst(pst),
      .en (en),
      .d  (d[i]),
      .q  (q[i])
    );
  end

endmodule

// File: tb/tb_regn_preset_en.sv
// Directed bench for regn_preset_en at widths 8, 1 and 32.
// All instances share clock and controls; data differs per width.
module tb_regn_preset_en;

  logic        clk;
  logic        clk_run;
  logic        rst;
  logic        pst;
  logic        en;
  logic [7:0]  d8;
  logic [7:0]  q8;
  logic [0:0]  d1;
  logic [0:0]  q1;
  logic [31:0] d32;
  logic [31:0] q32;

  int checks;
  int failures;

  regn_preset_en #(.n(8)) u8 (
    .clk(clk), .rst(rst), .pst(pst), .en(en), .d(d8), .q(q8)
  );

  regn_preset_en #(.n(1)) u1 (
    .clk(clk), .rst(rst), .pst(pst), .en(en), .d(d1), .q(q1)
  );

  regn_preset_en #(
    .n(32), .PRESET_VAL(32'hA5A5_A5A5)
  ) u32 (
    .clk(clk), .rst(rst), .pst(pst), .en(en), .d(d32), .q(q32)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #10;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk_run = 1'b0;
    rst = 1'b0;
    pst = 1'b0;
    en = 1'b0;
    d8 = 8'h00;
    d1 = 1'b0;
    d32 = 32'h0;

    // reset with clock stopped
    #5 rst = 1'b1;
    #1;
    check("rst_noclk_q8", {24'h0, q8}, 32'h0);
    check("rst_noclk_q1", {31'h0, q1}, 32'h0);
    check("rst_noclk_q32", q32, 32'h0);

    // reset holds across enabled edges
    clk_run = 1'b1;
    en = 1'b1;
    d8 = 8'h5A;
    d1 = 1'b1;
    d32 = 32'hFFFF_0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_q8", {24'h0, q8}, 32'h0);
    check("rst_hold_q32", q32, 32'h0);

    // rst and pst together: reset wins
    @(negedge clk);
    pst = 1'b1;
    #1;
    check("rst_pst_q8", {24'h0, q8}, 32'h0);
    check("rst_pst_q32", q32, 32'h0);

    // release both with en low, then preset alone
    en = 1'b0;
    pst = 1'b0;
    rst = 1'b0;
    #1;
    check("release_q8", {24'h0, q8}, 32'h0);
    pst = 1'b1;
    #1;
    check("pst_q8", {24'h0, q8}, 32'h0000_00FF);
    check("pst_q1", {31'h0, q1}, 32'h1);
    check("pst_q32", q32, 32'hA5A5_A5A5);
    rst = 1'b1;
    #1;
    check("pst_then_rst_q8", {24'h0, q8}, 32'h0);
    rst = 1'b0;
    pst = 1'b0;
    #1;
    pst = 1'b1;
    #1;
    check("pst_again_q8", {24'h0, q8}, 32'h0000_00FF);

    // load after preset release
    @(negedge clk);
    pst = 1'b0;
    en = 1'b1;
    d8 = 8'h03;
    d1 = 1'b0;
    d32 = 32'h1234_5678;
    #1;
    check("load_early_q8", {24'h0, q8}, 32'h0000_00FF);
    check("load_early_q32", q32, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    check("load_q8", {24'h0, q8}, 32'h0000_0003);
    check("load_q1", {31'h0, q1}, 32'h0);
    check("load_q32", q32, 32'h1234_5678);

    // hold for two edges with new data present
    @(negedge clk);
    en = 1'b0;
    d8 = 8'h0A;
    d1 = 1'b1;
    d32 = 32'hDEAD_BEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hold_q8", {24'h0, q8}, 32'h0000_0003);
    check("hold_q1", {31'h0, q1}, 32'h0);
    check("hold_q32", q32, 32'h1234_5678);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("reload_q8", {24'h0, q8}, 32'h0000_000A);
    check("reload_q1", {31'h0, q1}, 32'h1);
    check("reload_q32", q32, 32'hDEAD_BEEF);

    // async clear between edges while loading every cycle
    @(negedge clk);
    d8 = 8'h77;
    @(posedge clk);
    #1;
    check("stream_q8", {24'h0, q8}, 32'h0000_0077);
    #4 rst = 1'b1;
    #1;
    check("mid_rst_q8", {24'h0, q8}, 32'h0);
    check("mid_rst_q32", q32, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    d8 = 8'h99;
    #1;
    check("post_rst_q8", {24'h0, q8}, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_load_q8", {24'h0, q8}, 32'h0000_0099);
    check("post_rst_load_q32", q32, 32'hDEAD_BEEF);

    // async preset between edges, then reload
    #4 pst = 1'b1;
    #1;
    check("mid_pst_q8", {24'h0, q8}, 32'h0000_00FF);
    check("mid_pst_q32", q32, 32'hA5A5_A5A5);
    @(negedge clk);
    pst = 1'b0;
    d8 = 8'h42;
    d32 = 32'h0F0F_F0F0;
    @(posedge clk);
    #1;
    check("post_pst_load_q8", {24'h0, q8}, 32'h0000_0042);
    check("post_pst_load_q32", q32, 32'h0F0F_F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
